// File: rtl/spi_slave_sck_engine.sv
// rtl/spi_slave_sck_engine.sv - system-clock SPI slave SCK engine: sync, edge decode, bit counting
module spi_slave_sck_engine #(
    parameter  int DATA_WIDTH  = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int CNT_W       = $clog2(DATA_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCK_in,
    input  logic             SS_n,
    input  logic             CPOL,
    input  logic             CPHA,
    output logic             load_en,
    output logic             shift_en,
    output logic             sample_en,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_abort,
    output logic             mode_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sck_s;
    logic                   ss_s;
    logic                   sck_d;
    logic                   cpol_q;
    logic                   cpha_q;
    logic                   frame_wrap;
    logic                   sck_edge;
    logic                   lead;
    logic                   trail;
    logic                   do_sample;
    logic                   do_drive;

    // Pin synchronisers; SS_n idles deasserted so a reset never looks like a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            ss_sync  <= '1;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK_in};
            ss_sync  <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sck_d    <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ss_s  = ss_sync[SYNC_STAGES-1];

    // Edge classification relative to the polarity latched at frame start
    always_comb begin
        sck_edge  = sck_s ^ sck_d;
        lead      = sck_edge & (sck_s ^ cpol_q);
        trail     = sck_edge & ~(sck_s ^ cpol_q);
        do_sample = cpha_q ? trail : lead;
        do_drive  = cpha_q ? lead : trail;
    end

    // Frame FSM with registered single-cycle enables; SS release wins over any edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            frame_wrap  <= 1'b0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            load_en     <= 1'b0;
            shift_en    <= 1'b0;
            sample_en   <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            mode_err    <= 1'b0;
        end else begin
            load_en     <= 1'b0;
            shift_en    <= 1'b0;
            sample_en   <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ss_s) begin
                        state      <= ACTIVE;
                        busy       <= 1'b1;
                        cpol_q     <= CPOL;
                        cpha_q     <= CPHA;
                        bit_cnt    <= '0;
                        frame_wrap <= 1'b0;
                        if (sck_s != CPOL) begin
                            mode_err <= 1'b1;
                        end
                        if (!CPHA) begin
                            load_en <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_s) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        bit_cnt    <= '0;
                        frame_wrap <= 1'b0;
                        if (bit_cnt != '0) begin
                            frame_abort <= 1'b1;
                        end
                    end else if (do_sample) begin
                        sample_en <= 1'b1;
                        if (bit_cnt == LAST_CNT) begin
                            bit_cnt    <= '0;
                            frame_done <= 1'b1;
                            frame_wrap <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (do_drive) begin
                        frame_wrap <= 1'b0;
                        // CPHA=1 drives on the leading edge: first of the frame loads.
                        // CPHA=0 drives on the trailing edge: the one after a full word loads.
                        if (cpha_q ? (bit_cnt == '0) : frame_wrap) begin
                            load_en <= 1'b1;
                        end else begin
                            shift_en <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_sck_engine.sv
// tb/tb_spi_slave_sck_engine.sv - scoreboard bench for spi_slave_sck_engine
module tb_spi_slave_sck_engine;

    localparam int HALF = 5;
    localparam logic [4:0] LD = 5'd1;
    localparam logic [4:0] SH = 5'd2;
    localparam logic [4:0] SA = 5'd4;
    localparam logic [4:0] DN = 5'd8;
    localparam logic [4:0] AB = 5'd16;

    typedef struct {
        logic [4:0] code;
        int         cnt;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic ss8_n = 1'b1;
    logic ss16_n = 1'b1;
    logic cpol = 1'b0;
    logic cpha = 1'b0;

    logic       load8, shift8, sample8, busy8, done8, abort8, merr8;
    logic [3:0] cnt8;
    logic       load16, shift16, sample16, busy16, done16, abort16, merr16;
    logic [4:0] cnt16;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    ev_t q8[$];
    ev_t q16[$];

    spi_slave_sck_engine #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .SCK_in(sck), .SS_n(ss8_n), .CPOL(cpol), .CPHA(cpha),
        .load_en(load8), .shift_en(shift8), .sample_en(sample8), .bit_cnt(cnt8),
        .busy(busy8), .frame_done(done8), .frame_abort(abort8), .mode_err(merr8)
    );

    spi_slave_sck_engine #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .SCK_in(sck), .SS_n(ss16_n), .CPOL(cpol), .CPHA(cpha),
        .load_en(load16), .shift_en(shift16), .sample_en(sample16), .bit_cnt(cnt16),
        .busy(busy16), .frame_done(done16), .frame_abort(abort16), .mode_err(merr16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_ev(input bit w16, input logic [4:0] code, input int cnt);
        ev_t e;
        tests++;
        if ((w16 ? q16.size() : q8.size()) == 0) begin
            fails++;
            $display("FAIL unexpected_event dut%0d: code=%b cnt=%0d cyc=%0d, none expected",
                     w16 ? 16 : 8, code, cnt, cyc);
        end else begin
            e = w16 ? q16.pop_front() : q8.pop_front();
            if (e.code !== code || e.cnt != cnt || e.cyc != cyc) begin
                fails++;
                $display("FAIL event dut%0d: got code=%b cnt=%0d cyc=%0d, expected code=%b cnt=%0d cyc=%0d",
                         w16 ? 16 : 8, code, cnt, cyc, e.code, e.cnt, e.cyc);
            end
        end
    endtask

    // Monitor: every pulse from either DUT is matched against its scoreboard queue
    always @(negedge clk) begin
        if (!rst) begin
            if ({abort8, done8, sample8, shift8, load8} != 5'd0)
                check_ev(1'b0, {abort8, done8, sample8, shift8, load8}, int'(cnt8));
            if ({abort16, done16, sample16, shift16, load16} != 5'd0)
                check_ev(1'b1, {abort16, done16, sample16, shift16, load16}, int'(cnt16));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit w16, input logic [4:0] code, input int cnt);
        ev_t e;
        e.code = code;
        e.cnt  = cnt;
        e.cyc  = cyc + 3;
        if (w16) q16.push_back(e);
        else     q8.push_back(e);
    endtask

    task automatic drive_sck(input bit w16, input logic v, input logic [4:0] code, input int cnt);
        sck = v;
        if (code != 5'd0) push(w16, code, cnt);
        wait_clk(HALF);
    endtask

    task automatic drive_ss(input bit w16, input logic v, input logic [4:0] code, input int cnt);
        if (w16) ss16_n = v;
        else     ss8_n = v;
        if (code != 5'd0) push(w16, code, cnt);
        wait_clk(HALF);
    endtask

    // CPHA=0 frame pulses: leading edge samples, trailing edge shifts or reloads after a full word
    task automatic mode0_pulses(input bit w16, input int width, input int n, input logic idle);
        for (int i = 0; i < n; i++) begin
            drive_sck(w16, ~idle, (i % width == width - 1) ? (SA | DN) : SA,
                      (i % width == width - 1) ? 0 : (i % width) + 1);
            drive_sck(w16, idle, (i % width == width - 1) ? LD : SH,
                      (i % width == width - 1) ? 0 : (i % width) + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        wait_clk(3);
        chk("reset_outputs8", int'({load8, shift8, sample8, busy8, done8, abort8, merr8}), 0);
        chk("reset_cnt8", int'(cnt8), 0);
        chk("reset_busy16", int'({busy16, merr16, cnt16}), 0);
        rst = 1'b0;
        wait_clk(4);

        // 1: mode 0, one 8-bit frame
        cpol = 1'b0; cpha = 1'b0;
        drive_ss(1'b0, 1'b0, LD, 0);
        chk("t1_busy", int'(busy8), 1);
        mode0_pulses(1'b0, 8, 8, 1'b0);
        chk("t1_cnt", int'(cnt8), 0);
        drive_ss(1'b0, 1'b1, 5'd0, 0);
        chk("t1_idle", int'(busy8), 0);

        // 2: mode 3, two back-to-back frames
        cpol = 1'b1; cpha = 1'b1;
        drive_sck(1'b0, 1'b1, 5'd0, 0);
        drive_ss(1'b0, 1'b0, 5'd0, 0);
        for (int i = 0; i < 16; i++) begin
            drive_sck(1'b0, 1'b0, (i % 8 == 0) ? LD : SH, i % 8);
            drive_sck(1'b0, 1'b1, (i % 8 == 7) ? (SA | DN) : SA, (i % 8 == 7) ? 0 : (i % 8) + 1);
        end
        drive_ss(1'b0, 1'b1, 5'd0, 0);

        // 3: mode 1, abort after 5 bits, then an empty frame without abort
        cpol = 1'b0; cpha = 1'b1;
        drive_sck(1'b0, 1'b0, 5'd0, 0);
        drive_ss(1'b0, 1'b0, 5'd0, 0);
        for (int i = 0; i < 5; i++) begin
            drive_sck(1'b0, 1'b1, (i == 0) ? LD : SH, i);
            drive_sck(1'b0, 1'b0, SA, i + 1);
        end
        chk("t3_cnt_before", int'(cnt8), 5);
        drive_ss(1'b0, 1'b1, AB, 0);
        chk("t3_after_abort", int'({busy8, cnt8}), 0);
        drive_ss(1'b0, 1'b0, 5'd0, 0);
        drive_ss(1'b0, 1'b1, 5'd0, 0);
        chk("t3_merr_clear", int'(merr8), 0);

        // 4: CPOL=1 with SCK low at frame start
        cpol = 1'b1; cpha = 1'b0;
        drive_ss(1'b0, 1'b0, LD, 0);
        chk("t4_merr_set", int'(merr8), 1);
        drive_sck(1'b0, 1'b1, SH, 0);
        drive_sck(1'b0, 1'b0, SA, 1);
        drive_sck(1'b0, 1'b1, SH, 1);
        drive_sck(1'b0, 1'b0, SA, 2);
        drive_ss(1'b0, 1'b1, AB, 0);
        chk("t4_merr_sticky", int'(merr8), 1);

        // 5: mode 2 with CPOL/CPHA flipped mid-frame
        drive_sck(1'b0, 1'b1, 5'd0, 0);
        cpol = 1'b1; cpha = 1'b0;
        drive_ss(1'b0, 1'b0, LD, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                cpol = 1'b0; cpha = 1'b1;
            end
            drive_sck(1'b0, 1'b0, (i == 7) ? (SA | DN) : SA, (i == 7) ? 0 : i + 1);
            drive_sck(1'b0, 1'b1, (i == 7) ? LD : SH, (i == 7) ? 0 : i + 1);
        end
        drive_ss(1'b0, 1'b1, 5'd0, 0);

        // 5b: 16-bit instance, mode 0
        cpol = 1'b0; cpha = 1'b0;
        drive_sck(1'b1, 1'b0, 5'd0, 0);
        drive_ss(1'b1, 1'b0, LD, 0);
        mode0_pulses(1'b1, 16, 16, 1'b0);
        chk("t5_cnt16", int'(cnt16), 0);
        drive_ss(1'b1, 1'b1, 5'd0, 0);
        chk("t5_merr16", int'(merr16), 0);

        // 6: reset during bit 4, then a fresh frame
        drive_ss(1'b0, 1'b0, LD, 0);
        mode0_pulses(1'b0, 8, 3, 1'b0);
        chk("t6_pre_reset", int'({busy8, cnt8}), 16 + 3);
        sck = 1'b1;
        wait_clk(1);
        rst = 1'b1;
        #1;
        chk("t6_reset_now", int'({load8, shift8, sample8, busy8, done8, abort8, merr8, cnt8}), 0);
        ss8_n = 1'b1;
        sck = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(HALF);
        drive_ss(1'b0, 1'b0, LD, 0);
        drive_sck(1'b0, 1'b1, SA, 1);
        drive_sck(1'b0, 1'b0, SH, 1);
        drive_ss(1'b0, 1'b1, AB, 0);
        chk("t6_merr_after_rst", int'(merr8), 0);

        wait_clk(10);
        chk("q8_drained", q8.size(), 0);
        chk("q16_drained", q16.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
